cnn_window_gen: RTL and testbench

- Upstream neighbour of the single-cell CNN datapath.
- Accepts a raster-order pixel stream for one IMG_H x IMG_W frame and emits the zero-padded 3x3 neighbourhood around every pixel, one window per cycle.
- Window outputs U1..U9 connect directly to the cell's U1..U9 inputs; window position tags the result for the downstream write-back.

---
 rtl/cnn_window_gen.sv | 191 +++++++++++++++++++
 tb/tb_cnn_window_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_window_gen.sv
// Zero-padded 3x3 window generator: turns a raster pixel stream into one
// neighbourhood per pixel for the single-cell CNN datapath.
module cnn_window_gen #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int RW = $clog2(IMG_H),
  localparam int CW = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pixel,
  output logic             out_valid,
  output logic [WIDTH-1:0] U1,
  output logic [WIDTH-1:0] U2,
  output logic [WIDTH-1:0] U3,
  output logic [WIDTH-1:0] U4,
  output logic [WIDTH-1:0] U5,
  output logic [WIDTH-1:0] U6,
  output logic [WIDTH-1:0] U7,
  output logic [WIDTH-1:0] U8,
  output logic [WIDTH-1:0] U9,
  output logic [RW-1:0]    win_row,
  output logic [CW-1:0]    win_col,
  output logic             frame_done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int SL = 2 * IMG_W + 3;
  localparam int VW = $clog2(N + IMG_W + 1);

  localparam logic [VW-1:0] V_FIRST     = VW'(IMG_W + 1);
  localparam logic [VW-1:0] V_LOAD_LAST = VW'(N - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(N + IMG_W);
  localparam logic [RW-1:0] R_LAST      = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST      = CW'(IMG_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [VW-1:0]    v_q, v_d;
  logic [RW-1:0]    cen_row_q;
  logic [CW-1:0]    cen_col_q;
  logic             shift, emit;
  logic [WIDTH-1:0] shift_in;

  // The incoming sample is tap 0 of the 2*IMG_W+3 line; only the older
  // 2*IMG_W+2 samples need flops.
  logic [WIDTH-1:0] sr_q [SL-1];
  logic [WIDTH-1:0] sr_d [SL];
  logic [WIDTH-1:0] tap  [9];
  logic [WIDTH-1:0] win_q [9];
  logic             top, bot, lft, rgt;
  logic             out_valid_q, frame_done_q;
  logic [RW-1:0]    win_row_q;
  logic [CW-1:0]    win_col_q;

  assign in_ready = !rst && (state_q == ST_IDLE || state_q == ST_LOAD);

  always_comb begin
    shift    = 1'b0;
    shift_in = '0;
    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (in_valid) begin
          shift    = 1'b1;
          shift_in = in_pixel;
        end
      end
      ST_FLUSH: shift = 1'b1;
      default:  shift = 1'b0;
    endcase
  end

  assign emit = shift && (v_q >= V_FIRST);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_LOAD;
          v_d     = VW'(1);
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          v_d = v_q + VW'(1);
          if (v_q == V_LOAD_LAST) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (v_q == V_LAST) begin
          state_d = ST_IDLE;
          v_d     = '0;
        end else begin
          v_d = v_q + VW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        v_d     = '0;
      end
    endcase
  end

  always_comb begin
    sr_d[0] = shift_in;
    for (int i = 1; i < SL; i++) sr_d[i] = sr_q[i-1];
  end

  // Top-row taps would otherwise see the previous frame's tail; column edges
  // would see the neighbouring row.
  always_comb begin
    top    = (cen_row_q == '0);
    bot    = (cen_row_q == R_LAST);
    lft    = (cen_col_q == '0);
    rgt    = (cen_col_q == C_LAST);
    tap[0] = (top || lft) ? '0 : sr_d[2*IMG_W+2];
    tap[1] = top          ? '0 : sr_d[2*IMG_W+1];
    tap[2] = (top || rgt) ? '0 : sr_d[2*IMG_W];
    tap[3] = lft          ? '0 : sr_d[IMG_W+2];
    tap[4] = sr_d[IMG_W+1];
    tap[5] = rgt          ? '0 : sr_d[IMG_W];
    tap[6] = (bot || lft) ? '0 : sr_d[2];
    tap[7] = bot          ? '0 : sr_d[1];
    tap[8] = (bot || rgt) ? '0 : sr_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      v_q       <= '0;
      cen_row_q <= '0;
      cen_col_q <= '0;
      for (int i = 0; i < SL - 1; i++) sr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      if (shift) begin
        for (int i = 0; i < SL - 1; i++) sr_q[i] <= sr_d[i];
      end
      if (emit) begin
        if (cen_col_q == C_LAST) begin
          cen_col_q <= '0;
          cen_row_q <= (cen_row_q == R_LAST) ? '0 : cen_row_q + RW'(1);
        end else begin
          cen_col_q <= cen_col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= emit && (cen_row_q == R_LAST) && (cen_col_q == C_LAST);
      if (emit) begin
        win_row_q <= cen_row_q;
        win_col_q <= cen_col_q;
        for (int i = 0; i < 9; i++) win_q[i] <= tap[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign U1 = win_q[0];
  assign U2 = win_q[1];
  assign U3 = win_q[2];
  assign U4 = win_q[3];
  assign U5 = win_q[4];
  assign U6 = win_q[5];
  assign U7 = win_q[6];
  assign U8 = win_q[7];
  assign U9 = win_q[8];

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen: driver pushes reference windows from a
// coordinate-based padding model, monitor pops and compares on out_valid.
module tb_cnn_window_gen;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int WD = 9;
  localparam int NP = W * H;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [WD-1:0] in_pixel = '0;
  logic          in_ready, out_valid, frame_done;
  logic [WD-1:0] U1, U2, U3, U4, U5, U6, U7, U8, U9;
  logic [1:0]    win_row, win_col;

  cnn_window_gen #(.WIDTH(WD), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .out_valid(out_valid),
    .U1(U1), .U2(U2), .U3(U3), .U4(U4), .U5(U5), .U6(U6), .U7(U7), .U8(U8), .U9(U9),
    .win_row(win_row), .win_col(win_col), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [9*WD-1:0] u;
    logic [1:0]      r;
    logic [1:0]      c;
    logic            fd;
  } exp_t;

  exp_t          sbq[$];
  exp_t          e;
  logic [WD-1:0] fr [NP];
  int            checks = 0;
  int            errors = 0;
  int            acc_cyc = 0;
  bit            lat_chk = 0;
  bit            dir_chk = 0;
  bit            b2b_chk = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Window around centre k: every tap is the frame pixel at that coordinate, or 0 outside.
  function automatic exp_t model(input int k);
    exp_t x;
    int   r, c, rr, cc;
    r = k / W;
    c = k % W;
    x.u = '0;
    for (int t = 0; t < 9; t++) begin
      rr = r + t / 3 - 1;
      cc = c + t % 3 - 1;
      if (rr >= 0 && rr < H && cc >= 0 && cc < W) x.u[(8-t)*WD +: WD] = fr[rr*W+cc];
    end
    x.r  = 2'(r);
    x.c  = 2'(c);
    x.fd = (k == NP - 1);
    return x;
  endfunction

  function automatic logic [9*WD-1:0] pack9(input int a, b, c, d, f, g, h, i, j);
    return {WD'(a), WD'(b), WD'(c), WD'(d), WD'(f), WD'(g), WD'(h), WD'(i), WD'(j)};
  endfunction

  logic [9*WD+3:0] cur, last;
  assign cur = {U1, U2, U3, U4, U5, U6, U7, U8, U9, win_row, win_col};
  int win_cnt = 0;
  int run = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_state", 128'({out_valid, frame_done, in_ready, cur}), 128'(0));
      last    = cur;
      win_cnt = 0;
      run     = 0;
    end else begin
      if (!in_ready) run++;
      else begin
        if (run > 0) check("flush_ready_low", 128'(run), 128'(W + 1));
        run = 0;
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: got out_valid=1 at (%0d,%0d) expected none", win_row,
                   win_col);
        end else begin
          e = sbq.pop_front();
          check("window", 128'({cur, frame_done}), 128'({e.u, e.r, e.c, e.fd}));
        end
        if (lat_chk && win_cnt == 0) begin
          check("first_latency", 128'(cyc - acc_cyc), 128'(W + 2));
          lat_chk = 0;
        end
        if (dir_chk) begin
          case (win_cnt)
            0:  check("dir_c00", 128'(cur), 128'({pack9(0, 0, 0, 0, 1, 2, 0, 5, 6), 4'b0000}));
            5:  check("dir_c11", 128'(cur), 128'({pack9(1, 2, 3, 5, 6, 7, 9, 10, 11), 4'b0101}));
            7:  check("dir_c13", 128'(cur), 128'({pack9(3, 4, 0, 7, 8, 0, 11, 12, 0), 4'b0111}));
            11: begin
              check("dir_c23", 128'({cur, frame_done}),
                    128'({pack9(7, 8, 0, 11, 12, 0, 0, 0, 0), 4'b1011, 1'b1}));
              dir_chk = 0;
            end
            default: ;
          endcase
        end
        win_cnt = (win_cnt == NP - 1) ? 0 : win_cnt + 1;
        last    = cur;
      end else begin
        check("hold", 128'(cur), 128'(last));
      end
    end
  end

  task automatic run_frame(input int gap_pct, input int abort_at, input bit keep);
    int i;
    int guard;
    i = 0;
    guard = 0;
    for (int k = 0; k < NP; k++) sbq.push_back(model(k));
    while (i < NP) begin
      @(negedge clk);
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_pixel = fr[i];
      end
      #1;
      if (in_valid && in_ready) begin
        if (i == 0) begin
          acc_cyc = cyc;
          lat_chk = (gap_pct == 0);
          if (b2b_chk) begin
            check("b2b_accept_with_done", 128'({out_valid, frame_done}), 128'(2'b11));
            b2b_chk = 0;
          end
        end
        i++;
        if (i == abort_at) begin
          @(posedge clk);
          #1;
          rst = 1'b1;
          in_valid = 1'b0;
          sbq.delete();
          lat_chk = 0;
          repeat (3) @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      guard++;
      if (guard > 1000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got %0d accepts expected %0d", i, NP);
        return;
      end
    end
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sbq.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    check("drain_empty", 128'(sbq.size()), 128'(0));
  endtask

  task automatic rand_frame();
    for (int i = 0; i < NP; i++) fr[i] = WD'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NP; i++) fr[i] = WD'(i + 1);
    dir_chk = 1;
    run_frame(0, 0, 0);
    drain();
    check("dir_all_seen", 128'(dir_chk), 128'(0));

    for (int i = 0; i < NP; i++) fr[i] = (i % 2 != 0) ? WD'(255) : WD'(-256);
    run_frame(40, 0, 0);
    drain();

    rand_frame();
    run_frame(0, 7, 0);
    repeat (5) @(negedge clk);
    rand_frame();
    run_frame(0, 0, 0);
    drain();

    rand_frame();
    run_frame(0, 0, 1);
    rand_frame();
    b2b_chk = 1;
    run_frame(0, 0, 0);
    drain();
    check("b2b_seen", 128'(b2b_chk), 128'(0));

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      run_frame(30, 0, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
